onchip_mem_arbiter: RTL and testbench

ONCHIP_MEM_ARBITER -- requirements
Module: onchip_mem_arbiter

---
 rtl/onchip_mem_arbiter.sv | 102 ++++++++++
 tb/tb_onchip_mem_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// Two-master Avalon-MM arbiter in front of a shared single-port RAM.
// Zero-wait-state grants, round-robin on conflict, one-cycle read latency.
module onchip_mem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,

    input  logic                  halt
);

    logic w_req0;
    logic w_req1;
    logic w_gnt;
    logic w_sel;
    logic w_is_write;

    logic r_rd_pend;
    logic r_rd_src;
    logic r_last_grant;

    assign w_req0 = m0_read | m0_write;
    assign w_req1 = m1_read | m1_write;

    // w_sel stays 0 without a grant so the RAM bus is driven from master 0
    always_comb begin
        w_gnt = 1'b0;
        w_sel = 1'b0;
        if (!reset && !halt) begin
            if (w_req0 && w_req1) begin
                w_gnt = 1'b1;
                w_sel = ~r_last_grant;
            end else if (w_req0) begin
                w_gnt = 1'b1;
                w_sel = 1'b0;
            end else if (w_req1) begin
                w_gnt = 1'b1;
                w_sel = 1'b1;
            end
        end
    end

    assign w_is_write = w_sel ? m1_write : m0_write;

    assign mem_chipselect = w_gnt;
    assign mem_write      = w_gnt & w_is_write;
    assign mem_address    = w_sel ? m1_address    : m0_address;
    assign mem_byteenable = w_sel ? m1_byteenable : m0_byteenable;
    assign mem_writedata  = w_sel ? m1_writedata  : m0_writedata;
    assign mem_clken      = ~reset;

    assign m0_waitrequest = ~(w_gnt & ~w_sel);
    assign m1_waitrequest = ~(w_gnt &  w_sel);

    assign m0_readdata = mem_readdata;
    assign m1_readdata = mem_readdata;

    assign m0_readdatavalid = r_rd_pend & ~r_rd_src & ~reset;
    assign m1_readdatavalid = r_rd_pend &  r_rd_src & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_pend    <= 1'b0;
            r_rd_src     <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_rd_pend <= w_gnt & ~w_is_write;
            if (w_gnt) begin
                r_rd_src     <= w_sel;
                r_last_grant <= w_sel;
            end
        end
    end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter: directed per-cycle grant checks plus
// an in-order read-response queue drained by an independent monitor.
module tb_onchip_mem_arbiter;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] m0_address, m1_address;
    logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
    logic              m0_read, m0_write, m1_read, m1_write;
    logic [DATA_W-1:0] m0_writedata, m1_writedata;
    logic              m0_waitrequest, m1_waitrequest;
    logic [DATA_W-1:0] m0_readdata, m1_readdata;
    logic              m0_readdatavalid, m1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_writedata;
    logic [DATA_W-1:0] mem_readdata;
    logic              halt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic              src;
        logic [DATA_W-1:0] data;
    } rsp_t;
    rsp_t sb[$];

    always #5 clk = ~clk;

    onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .m0_address       (m0_address),
        .m0_byteenable    (m0_byteenable),
        .m0_read          (m0_read),
        .m0_write         (m0_write),
        .m0_writedata     (m0_writedata),
        .m0_waitrequest   (m0_waitrequest),
        .m0_readdata      (m0_readdata),
        .m0_readdatavalid (m0_readdatavalid),
        .m1_address       (m1_address),
        .m1_byteenable    (m1_byteenable),
        .m1_read          (m1_read),
        .m1_write         (m1_write),
        .m1_writedata     (m1_writedata),
        .m1_waitrequest   (m1_waitrequest),
        .m1_readdata      (m1_readdata),
        .m1_readdatavalid (m1_readdatavalid),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata),
        .halt             (halt)
    );

    // Single-port RAM, one-cycle read latency
    logic [DATA_W-1:0] ram [2**ADDR_W];
    logic [DATA_W-1:0] ram_q;
    assign mem_readdata = ram_q;

    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                for (int b = 0; b < BE_W; b++)
                    if (mem_byteenable[b])
                        ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                ram_q <= ram[mem_address];
            end
        end
    end

    task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every readdatavalid must match the oldest outstanding read
    always @(negedge clk) begin
        if (m0_readdatavalid || m1_readdatavalid) begin
            check("rdv_onehot", {31'd0, m0_readdatavalid & m1_readdatavalid}, 32'd0);
            if (sb.size() == 0) begin
                check("rdv_unexpected", {31'd0, m1_readdatavalid}, 32'hFFFF_FFFF);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rdv_src", {31'd0, m1_readdatavalid}, {31'd0, e.src});
                check("rdata", e.src ? m1_readdata : m0_readdata, e.data);
            end
        end
    end

    task automatic push_rsp(input logic src, input logic [DATA_W-1:0] data);
        rsp_t r;
        r.src  = src;
        r.data = data;
        sb.push_back(r);
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_address = '0; m1_address = '0;
        m0_byteenable = '0; m1_byteenable = '0;
        m0_writedata = '0; m1_writedata = '0;
    endtask

    task automatic m0rd(input logic [ADDR_W-1:0] a);
        m0_read = 1; m0_write = 0; m0_address = a; m0_byteenable = '1;
    endtask

    task automatic m1rd(input logic [ADDR_W-1:0] a);
        m1_read = 1; m1_write = 0; m1_address = a; m1_byteenable = '1;
    endtask

    task automatic m0wr(input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
        m0_read = 0; m0_write = 1; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask

    task automatic m1wr(input logic [ADDR_W-1:0] a, input logic [BE_W-1:0] be, input logic [DATA_W-1:0] d);
        m1_read = 0; m1_write = 1; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    // One normal cycle: check combinational grant outputs mid-cycle, then advance
    task automatic tick(input logic ewr0, input logic ewr1, input logic ecs, input logic ewe);
        @(negedge clk);
        check("m0_waitrequest", {31'd0, m0_waitrequest}, {31'd0, ewr0});
        check("m1_waitrequest", {31'd0, m1_waitrequest}, {31'd0, ewr1});
        check("mem_chipselect", {31'd0, mem_chipselect}, {31'd0, ecs});
        check("mem_write",      {31'd0, mem_write},      {31'd0, ewe});
        check("mem_clken",      {31'd0, mem_clken},      32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic rtick();
        @(negedge clk);
        check("rst_m0_wait", {31'd0, m0_waitrequest},   32'd1);
        check("rst_m1_wait", {31'd0, m1_waitrequest},   32'd1);
        check("rst_m0_rdv",  {31'd0, m0_readdatavalid}, 32'd0);
        check("rst_m1_rdv",  {31'd0, m1_readdatavalid}, 32'd0);
        check("rst_cs",      {31'd0, mem_chipselect},   32'd0);
        check("rst_we",      {31'd0, mem_write},        32'd0);
        check("rst_clken",   {31'd0, mem_clken},        32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1; halt = 0;
        idle();
        rtick();
        rtick();
        reset = 0;

        // Write then read-back on m0, first grant right after reset release
        m0wr(11'h005, 4'hF, 32'hDEADBEEF);             tick(0, 1, 1, 1);
        m0rd(11'h005); push_rsp(0, 32'hDEADBEEF);      tick(0, 1, 1, 0);
        idle();                                        tick(1, 1, 0, 0);

        // Preload, then simultaneous reads right after a reset
        m0wr(11'h010, 4'hF, 32'h11111111);             tick(0, 1, 1, 1);
        idle(); m1wr(11'h020, 4'hF, 32'h22222222);     tick(1, 0, 1, 1);
        idle(); reset = 1;                             rtick();
        reset = 0;
        m0rd(11'h010); m1rd(11'h020);
        push_rsp(0, 32'h11111111);                     tick(0, 1, 1, 0);
        idle(); m1rd(11'h020);
        push_rsp(1, 32'h22222222);                     tick(1, 0, 1, 0);
        idle();                                        tick(1, 1, 0, 0);

        // Continuous reads from both: strict alternation starting at m0
        m0rd(11'h010); m1rd(11'h020);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                push_rsp(0, 32'h11111111);             tick(0, 1, 1, 0);
            end else begin
                push_rsp(1, 32'h22222222);             tick(1, 0, 1, 0);
            end
        end
        idle();                                        tick(1, 1, 0, 0);

        // Partial byte-enable write on m1 at the top address
        m1wr(11'h7FF, 4'hF, 32'hFFFFFFFF);             tick(1, 0, 1, 1);
        m1wr(11'h7FF, 4'h3, 32'h0000ABCD);             tick(1, 0, 1, 1);
        idle();                                        tick(1, 1, 0, 0);
        m1rd(11'h7FF); push_rsp(1, 32'hFFFFABCD);      tick(1, 0, 1, 0);
        idle();                                        tick(1, 1, 0, 0);

        // Halt right after a read grant: response still completes, m0 stalls
        m1rd(11'h020); push_rsp(1, 32'h22222222);      tick(1, 0, 1, 0);
        idle(); halt = 1; m0rd(11'h005);
        for (int k = 0; k < 3; k++)                    tick(1, 1, 0, 0);
        halt = 0; push_rsp(0, 32'hDEADBEEF);           tick(0, 1, 1, 0);
        idle();                                        tick(1, 1, 0, 0);

        // Reset in the cycle after an m1 read grant drops the response
        m1rd(11'h020);                                 tick(1, 0, 1, 0);
        idle(); reset = 1;                             rtick();
        reset = 0;                                     tick(1, 1, 0, 0);
        m0rd(11'h010); m1rd(11'h020);
        push_rsp(0, 32'h11111111);                     tick(0, 1, 1, 0);
        idle(); m1rd(11'h020);
        push_rsp(1, 32'h22222222);                     tick(1, 0, 1, 0);
        idle();                                        tick(1, 1, 0, 0);
        tick(1, 1, 0, 0);

        check("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
